// File: rtl/gnr_node_multi.sv
// Gene-regulatory-network node state holder: N_LANES state copies with per-lane
// strobed commits, clock-divided slow lanes, settling detection and a change counter.
module gnr_node_multi #(
    parameter int unsigned        N_LANES       = 2,
    parameter int unsigned        WIDTH         = 1,
    parameter logic [N_LANES-1:0] SLOW_MASK     = N_LANES'(1),
    parameter int unsigned        PASS_DIV      = 2,
    parameter int unsigned        STABLE_THRESH = 4,
    parameter int unsigned        CNT_W         = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       reset_nos_i,
    input  logic [WIDTH-1:0]           init_state_i,
    input  logic [N_LANES-1:0]         start_i,
    input  logic [N_LANES*WIDTH-1:0]   next_state_i,
    output logic [N_LANES*WIDTH-1:0]   state_o,
    output logic [N_LANES-1:0]         stable_o,
    output logic                       all_stable_o,
    output logic [CNT_W-1:0]           change_cnt_o
);

    localparam int unsigned DIV_W  = 4;
    localparam int unsigned STAB_W = 8;
    localparam int unsigned SUM_W  = CNT_W + 8;

    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(PASS_DIV - 1);
    localparam logic [STAB_W-1:0] THRESH  = STAB_W'(STABLE_THRESH);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [N_LANES*WIDTH-1:0] state_q, state_d;
    logic [DIV_W-1:0]         div_q  [N_LANES];
    logic [DIV_W-1:0]         div_d  [N_LANES];
    logic [STAB_W-1:0]        stab_q [N_LANES];
    logic [STAB_W-1:0]        stab_d [N_LANES];
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SUM_W-1:0]         sum_c;
    logic                     commit_c;

    // Next-state: reset_nos re-seeds everything; otherwise each strobed lane may commit
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        stab_d   = stab_q;
        cnt_d    = cnt_q;
        sum_c    = SUM_W'(cnt_q);
        commit_c = 1'b0;
        if (reset_nos_i) begin
            state_d = {N_LANES{init_state_i}};
            cnt_d   = '0;
            for (int i = 0; i < int'(N_LANES); i++) begin
                div_d[i]  = DIV_MAX;
                stab_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < int'(N_LANES); i++) begin
                commit_c = 1'b0;
                if (start_i[i]) begin
                    commit_c = !SLOW_MASK[i] || (div_q[i] == DIV_MAX);
                    if (SLOW_MASK[i]) begin
                        div_d[i] = commit_c ? '0 : div_q[i] + DIV_W'(1);
                    end
                end
                if (commit_c) begin
                    state_d[i*WIDTH +: WIDTH] = next_state_i[i*WIDTH +: WIDTH];
                    if (next_state_i[i*WIDTH +: WIDTH] != state_q[i*WIDTH +: WIDTH]) begin
                        stab_d[i] = '0;
                        sum_c     = sum_c + SUM_W'(1);
                    end else if (stab_q[i] < THRESH) begin
                        stab_d[i] = stab_q[i] + STAB_W'(1);
                    end
                end
            end
            cnt_d = (sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < int'(N_LANES); i++) begin
                div_q[i]  <= '0;
                stab_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            stab_q  <= stab_d;
        end
    end

    for (genvar g = 0; g < int'(N_LANES); g++) begin : g_stable
        assign stable_o[g] = (stab_q[g] == THRESH);
    end

    assign state_o      = state_q;
    assign all_stable_o = &stable_o;
    assign change_cnt_o = cnt_q;

endmodule

// File: tb/tb_gnr_node_multi.sv
// Directed bench for gnr_node_multi: default config via vector table, plus
// saturation (CNT_W=3) and four-lane divided-commit sequences.
module tb_gnr_node_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Default instance
    logic       rst0 = 1'b0, rnos0 = 1'b0, init0 = 1'b0;
    logic [1:0] start0 = '0, nxt0 = '0, state0, stable0;
    logic       all0;
    logic [7:0] cnt0;

    gnr_node_multi u0 (
        .clk_i(clk), .rst_i(rst0), .reset_nos_i(rnos0), .init_state_i(init0),
        .start_i(start0), .next_state_i(nxt0), .state_o(state0),
        .stable_o(stable0), .all_stable_o(all0), .change_cnt_o(cnt0)
    );

    // Narrow counter instance
    logic       rst1 = 1'b0, rnos1 = 1'b0, init1 = 1'b0;
    logic [1:0] start1 = '0, nxt1 = '0, state1, stable1;
    logic       all1;
    logic [2:0] cnt1;

    gnr_node_multi #(.CNT_W(3)) u1 (
        .clk_i(clk), .rst_i(rst1), .reset_nos_i(rnos1), .init_state_i(init1),
        .start_i(start1), .next_state_i(nxt1), .state_o(state1),
        .stable_o(stable1), .all_stable_o(all1), .change_cnt_o(cnt1)
    );

    // Four-lane, 3-bit, divide-by-3 instance
    logic        rst2 = 1'b0, rnos2 = 1'b0;
    logic [2:0]  init2 = '0;
    logic [3:0]  start2 = '0, stable2;
    logic [11:0] nxt2 = '0, state2;
    logic        all2;
    logic [7:0]  cnt2;

    gnr_node_multi #(.N_LANES(4), .WIDTH(3), .SLOW_MASK(4'b1010), .PASS_DIV(3)) u2 (
        .clk_i(clk), .rst_i(rst2), .reset_nos_i(rnos2), .init_state_i(init2),
        .start_i(start2), .next_state_i(nxt2), .state_o(state2),
        .stable_o(stable2), .all_stable_o(all2), .change_cnt_o(cnt2)
    );

    typedef struct {
        logic       rst;
        logic       rnos;
        logic       init;
        logic [1:0] start;
        logic [1:0] nxt;
        logic [1:0] e_state;
        logic [1:0] e_stable;
        logic       e_all;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic n, logic in, logic [1:0] s, logic [1:0] nx,
                                logic [1:0] es, logic [1:0] est, logic ea, logic [7:0] ec);
        vec_t v;
        v.rst = r; v.rnos = n; v.init = in; v.start = s; v.nxt = nx;
        v.e_state = es; v.e_stable = est; v.e_all = ea; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  slow_v;
    logic [11:0] exp2;
    logic [7:0]  exp_cnt2 [6] = '{8'd4, 8'd6, 8'd8, 8'd12, 8'd14, 8'd16};

    initial begin
        //               rst  rnos init start  nxt    state  stable all cnt
        vt.push_back(mk(1'b1,1'b0,1'b0,2'b00,2'b00, 2'b00,2'b00,1'b0,8'd0)); // 0 rst
        vt.push_back(mk(1'b0,1'b1,1'b1,2'b11,2'b00, 2'b11,2'b00,1'b0,8'd0)); // 1 reset_nos beats start
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b11,2'b00, 2'b00,2'b00,1'b0,8'd2)); // 2 both commit, change
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b11,2'b00, 2'b00,2'b00,1'b0,8'd2)); // 3 lane0 skip
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b11,2'b00, 2'b00,2'b00,1'b0,8'd2)); // 4
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b11,2'b00, 2'b00,2'b00,1'b0,8'd2)); // 5 stab1=3
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b10,2'b00, 2'b00,2'b10,1'b0,8'd2)); // 6 lane1 stable
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b10,2'b00, 2'b00,2'b10,1'b0,8'd2)); // 7 saturated
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b10,2'b10, 2'b10,2'b00,1'b0,8'd3)); // 8 change drops stable
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b10, 2'b10,2'b00,1'b0,8'd3)); // 9 lane0 commit
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b10, 2'b10,2'b00,1'b0,8'd3)); // 10 skip
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b10, 2'b10,2'b00,1'b0,8'd3)); // 11 commit
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b10, 2'b10,2'b00,1'b0,8'd3)); // 12 skip
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b10, 2'b10,2'b01,1'b0,8'd3)); // 13 lane0 stable
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b10,2'b10, 2'b10,2'b01,1'b0,8'd3)); // 14
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b10,2'b10, 2'b10,2'b01,1'b0,8'd3)); // 15
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b10,2'b10, 2'b10,2'b01,1'b0,8'd3)); // 16
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b10,2'b10, 2'b10,2'b11,1'b1,8'd3)); // 17 all stable
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b11,2'b00, 2'b00,2'b01,1'b0,8'd4)); // 18 lane0 skip, lane1 change
        vt.push_back(mk(1'b1,1'b0,1'b0,2'b11,2'b11, 2'b00,2'b00,1'b0,8'd0)); // 19 rst beats start
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b01, 2'b00,2'b00,1'b0,8'd0)); // 20 first strobe skipped
        vt.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b01, 2'b01,2'b00,1'b0,8'd1)); // 21 second commits
        vt.push_back(mk(1'b0,1'b1,1'b0,2'b11,2'b11, 2'b00,2'b00,1'b0,8'd0)); // 22 reset_nos clears

        foreach (vt[i]) begin
            rst0 = vt[i].rst; rnos0 = vt[i].rnos; init0 = vt[i].init;
            start0 = vt[i].start; nxt0 = vt[i].nxt;
            tick();
            check("state",      i, 32'(state0),  32'(vt[i].e_state));
            check("stable",     i, 32'(stable0), 32'(vt[i].e_stable));
            check("all_stable", i, 32'(all0),    32'(vt[i].e_all));
            check("change_cnt", i, 32'(cnt0),    32'(vt[i].e_cnt));
        end
        rst0 = 1'b0; rnos0 = 1'b0; start0 = '0;

        // Counter saturation: lane1 toggles on every strobe
        rst1 = 1'b1; tick();
        rst1 = 1'b0; rnos1 = 1'b1; init1 = 1'b0; tick();
        rnos1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            logic [31:0] kk;
            kk = 32'(k);
            start1 = 2'b10;
            nxt1   = {kk[0], 1'b0};
            tick();
            check("sat_cnt", k, 32'(cnt1), (k > 7) ? 32'd7 : 32'(k));
        end
        start1 = '0;
        check("sat_state", 9, 32'(state1), 32'h2);

        // Four lanes, slow lanes 1 and 3 commit on strobes 1 and 4
        rst2 = 1'b1; tick();
        rst2 = 1'b0; rnos2 = 1'b1; init2 = 3'd0; tick();
        rnos2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            start2 = 4'b1111;
            nxt2   = {3'(k + 6), 3'(k + 4), 3'(k + 2), 3'(k)};
            tick();
            slow_v = (k < 4) ? 3'd1 : 3'd4;
            exp2   = {3'(slow_v + 3'd6), 3'(k + 4), 3'(slow_v + 3'd2), 3'(k)};
            check("div_state", k, 32'(state2), 32'(exp2));
            check("div_cnt",   k, 32'(cnt2),   32'(exp_cnt2[k-1]));
        end
        start2 = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
